uart_tx_param: RTL and testbench

UART_TX_PARAM -- requirements
Module: uart_tx_param

---
 rtl/uart_tx_param.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_param.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// rtl/uart_tx_param.sv - parameterised UART transmitter with a 1-deep holding register
// Frame: start, DATA_BITS data LSB first, optional parity, STOP_BITS stop; baud divisor latched per frame.
module uart_tx_param #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int DIV_WIDTH  = 32
) (
  input  logic                 clk_input,
  input  logic                 rst_n_input,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic [DATA_BITS-1:0] data_input,
  input  logic                 data_valid,
  output logic                 data_ready,
  output logic                 tx_pin,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int BW = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                 state_q, state_d;
  logic [DATA_BITS-1:0]   hold_q, hold_d;
  logic                   hold_full_q, hold_full_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic [DIV_WIDTH-1:0]   div_q, div_d;
  logic [DIV_WIDTH-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic                   tx_q, tx_d;
  logic                   done_q, done_d;
  logic                   bit_end;
  logic                   load;

  assign bit_end    = (cnt_q == div_q - DIV_WIDTH'(1));
  assign data_ready = ~hold_full_q;
  assign tx_pin     = tx_q;
  assign tx_busy    = (state_q != S_IDLE);
  assign tx_done    = done_q;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    par_d       = par_q;
    div_d       = div_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    tx_d        = tx_q;
    done_d      = 1'b0;
    load        = 1'b0;

    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + DIV_WIDTH'(1);
    end

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (hold_full_q) load = 1'b1;
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == BW'(DATA_BITS - 1)) begin
            bit_d = '0;
            if (PARITY_EN != 0) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            bit_d   = bit_q + BW'(1);
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_q == BW'(STOP_BITS - 1)) begin
            done_d = 1'b1;
            bit_d  = '0;
            if (hold_full_q) begin
              load = 1'b1;
            end else begin
              state_d = S_IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Back-to-back frames reuse this path so the next start bit follows the last stop bit directly.
    if (load) begin
      state_d     = S_START;
      tx_d        = 1'b0;
      shift_d     = hold_q;
      par_d       = (^hold_q) ^ (PARITY_ODD != 0);
      div_d       = (baud_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : baud_div;
      cnt_d       = '0;
      bit_d       = '0;
      hold_full_d = 1'b0;
    end

    if (data_valid && !hold_full_q) begin
      hold_d      = data_input;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_input or negedge rst_n_input) begin
    if (!rst_n_input) begin
      state_q     <= S_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      div_q       <= '0;
      cnt_q       <= '0;
      bit_q       <= '0;
      tx_q        <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      tx_q        <= tx_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb/tb_uart_tx_param.sv - directed bench for uart_tx_param (8N1, 8E1, 8O1, 8N2 instances)
module tb_uart_tx_param;

  logic        clk;
  logic        rst_n;
  logic [31:0] baud_div;
  logic [7:0]  data_input;
  logic [3:0]  valid_w;
  logic [3:0]  ready_w;
  logic [3:0]  tx_w;
  logic [3:0]  busy_w;
  logic [3:0]  done_w;

  int          errors;
  int          checks;
  int          ev_at [2];
  logic [7:0]  ev_dat [2];
  int          baud_at;
  logic [31:0] baud_new;

  uart_tx_param u0 (
    .clk_input(clk), .rst_n_input(rst_n), .baud_div(baud_div), .data_input(data_input),
    .data_valid(valid_w[0]), .data_ready(ready_w[0]), .tx_pin(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0])
  );
  uart_tx_param #(.PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .clk_input(clk), .rst_n_input(rst_n), .baud_div(baud_div), .data_input(data_input),
    .data_valid(valid_w[1]), .data_ready(ready_w[1]), .tx_pin(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1])
  );
  uart_tx_param #(.PARITY_EN(1), .PARITY_ODD(1)) u2 (
    .clk_input(clk), .rst_n_input(rst_n), .baud_div(baud_div), .data_input(data_input),
    .data_valid(valid_w[2]), .data_ready(ready_w[2]), .tx_pin(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2])
  );
  uart_tx_param #(.STOP_BITS(2)) u3 (
    .clk_input(clk), .rst_n_input(rst_n), .baud_div(baud_div), .data_input(data_input),
    .data_valid(valid_w[3]), .data_ready(ready_w[3]), .tx_pin(tx_w[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3])
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int inst, input logic [7:0] d);
    @(negedge clk);
    data_input    = d;
    valid_w[inst] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_w[inst] = 1'b0;
    check(32'(ready_w[inst]), 32'd0, "send_ready_low");
  endtask

  // bits is LSB-first: start at bit 0; each bit must hold for n samples from the cycle after the load edge
  task automatic observe(input int inst, input logic [15:0] bits, input int nb, input int n,
                         input logic done_first, input logic chk_low, input string tag);
    int bad, dbad, bbad, rbad, k;
    dbad = 0; bbad = 0; rbad = 0;
    for (int b = 0; b < nb; b++) begin
      bad = 0;
      for (int j = 0; j < n; j++) begin
        k = b * n + j;
        @(negedge clk);
        if (tx_w[inst] !== bits[b]) bad++;
        if (k == 0) check(32'(done_w[inst]), 32'(done_first), {tag, "_done_first"});
        else if (done_w[inst] !== 1'b0) dbad++;
        if (busy_w[inst] !== 1'b1) bbad++;
        if (chk_low && k > 0 && ready_w[inst] !== 1'b0) rbad++;
        if (k == ev_at[0] + 1 || k == ev_at[1] + 1) valid_w[inst] = 1'b0;
        for (int e = 0; e < 2; e++) begin
          if (k == ev_at[e]) begin
            data_input    = ev_dat[e];
            valid_w[inst] = 1'b1;
          end
        end
        if (k == baud_at) baud_div = baud_new;
      end
      check(32'(bad), 32'd0, $sformatf("%s_bit%0d", tag, b));
    end
    check(32'(dbad), 32'd0, {tag, "_no_early_done"});
    check(32'(bbad), 32'd0, {tag, "_busy"});
    if (chk_low) check(32'(rbad), 32'd0, {tag, "_ready_low"});
    ev_at[0] = -1; ev_at[1] = -1; baud_at = -1;
  endtask

  task automatic end_idle(input int inst, input string tag);
    @(negedge clk);
    check(32'(done_w[inst]), 32'd1, {tag, "_done_pulse"});
    check(32'(tx_w[inst]), 32'd1, {tag, "_idle_tx"});
    check(32'(busy_w[inst]), 32'd0, {tag, "_idle_busy"});
    check(32'(ready_w[inst]), 32'd1, {tag, "_idle_ready"});
    @(negedge clk);
    check(32'(done_w[inst]), 32'd0, {tag, "_done_once"});
  endtask

  initial begin
    int bad;
    errors = 0; checks = 0;
    clk = 1'b0; rst_n = 1'b0; baud_div = 32'd4; data_input = 8'h00; valid_w = 4'b0000;
    ev_at[0] = -1; ev_at[1] = -1; ev_dat[0] = 8'h00; ev_dat[1] = 8'h00; baud_at = -1; baud_new = 32'd4;

    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check(32'(tx_w[i]), 32'd1, "reset_tx");
      check(32'(ready_w[i]), 32'd1, "reset_ready");
      check(32'(busy_w[i]), 32'd0, "reset_busy");
      check(32'(done_w[i]), 32'd0, "reset_done");
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    send(0, 8'h55);
    observe(0, 16'({1'b1, 8'h55, 1'b0}), 10, 4, 1'b0, 1'b0, "f55");
    end_idle(0, "f55");

    send(1, 8'h07);
    observe(1, 16'({1'b1, 1'b1, 8'h07, 1'b0}), 11, 4, 1'b0, 1'b0, "even07");
    end_idle(1, "even07");
    send(2, 8'h07);
    observe(2, 16'({1'b1, 1'b0, 8'h07, 1'b0}), 11, 4, 1'b0, 1'b0, "odd07");
    end_idle(2, "odd07");

    @(negedge clk);
    data_input = 8'hA3;
    valid_w[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check(32'(ready_w[0]), 32'd0, "b2b_ready_full");
    data_input = 8'h3C;
    ev_at[0] = 0; ev_dat[0] = 8'h3C;
    observe(0, 16'({1'b1, 8'hA3, 1'b0}), 10, 4, 1'b0, 1'b1, "b2b_a3");
    observe(0, 16'({1'b1, 8'h3C, 1'b0}), 10, 4, 1'b1, 1'b0, "b2b_3c");
    end_idle(0, "b2b");

    baud_div = 32'd1;
    send(3, 8'h96);
    observe(3, 16'({2'b11, 8'h96, 1'b0}), 11, 2, 1'b0, 1'b0, "stop2");
    end_idle(3, "stop2");
    baud_div = 32'd4;

    send(0, 8'h00);
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      if (k == 2) begin
        data_input = 8'hFF;
        valid_w[0] = 1'b1;
      end
      if (k == 3) valid_w[0] = 1'b0;
    end
    check(32'(tx_w[0]), 32'd0, "rst_pre_tx");
    check(32'(ready_w[0]), 32'd0, "rst_pre_ready");
    rst_n = 1'b0;
    #1;
    check(32'(tx_w[0]), 32'd1, "rst_tx");
    check(32'(ready_w[0]), 32'd1, "rst_ready");
    check(32'(busy_w[0]), 32'd0, "rst_busy");
    check(32'(done_w[0]), 32'd0, "rst_done");
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (tx_w[0] !== 1'b1 || done_w[0] !== 1'b0 || busy_w[0] !== 1'b0) bad++;
    end
    check(32'(bad), 32'd0, "rst_discard_pending");
    send(0, 8'h81);
    observe(0, 16'({1'b1, 8'h81, 1'b0}), 10, 4, 1'b0, 1'b0, "after_rst81");
    end_idle(0, "after_rst81");

    send(0, 8'h3C);
    ev_at[0] = 0; ev_dat[0] = 8'hC5;
    ev_at[1] = 8; ev_dat[1] = 8'h11;
    baud_at = 0; baud_new = 32'd8;
    observe(0, 16'({1'b1, 8'h3C, 1'b0}), 10, 4, 1'b0, 1'b1, "baud4");
    observe(0, 16'({1'b1, 8'hC5, 1'b0}), 10, 8, 1'b1, 1'b0, "baud8");
    end_idle(0, "baud8");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
